// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module  : regfile_pkg
// Purpose : Shared types and default sizing for the 2R1W register file.
// Revision: 1.0  initial release
// ============================================================================
package regfile_pkg;

    localparam int RF_WIDTH_DEFAULT = 16;
    localparam int RF_DEPTH_DEFAULT = 16;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_e;

endpackage : regfile_pkg
`default_nettype wire

// File: rtl/rf_read_port.sv
`default_nettype none
// ============================================================================
// Module  : rf_read_port
// Purpose : Registered read port with write bypass and out-of-range masking.
// Revision: 1.0  initial release
// ============================================================================
module rf_read_port
    import regfile_pkg::*;
#(
    parameter int WIDTH = RF_WIDTH_DEFAULT,
    parameter int DEPTH = RF_DEPTH_DEFAULT,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         rd_en_i,
    input  logic [ADDR_W-1:0]            rd_addr_i,
    input  logic [DEPTH-1:0][WIDTH-1:0]  mem_i,
    input  logic                         wr_fire_i,
    input  logic [ADDR_W-1:0]            wr_addr_i,
    input  logic [WIDTH-1:0]             wr_data_i,
    output logic [WIDTH-1:0]             rd_data_o
);

    localparam logic [ADDR_W:0] c_DEPTH_EXT = (ADDR_W+1)'(DEPTH);

    logic             w_in_range;
    logic [WIDTH-1:0] w_arr_data;
    logic [WIDTH-1:0] rd_data_d;
    logic [WIDTH-1:0] rd_data_q;

    assign w_in_range = ({1'b0, rd_addr_i} < c_DEPTH_EXT);

    always_comb begin
        w_arr_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (rd_addr_i == ADDR_W'(i)) begin
                w_arr_data = mem_i[i];
            end
        end
    end

    // wr_fire_i is only high for in-range accepted writes, so forwarding never leaks
    // data for a masked address.
    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en_i) begin
            if (wr_fire_i && (wr_addr_i == rd_addr_i)) begin
                rd_data_d = wr_data_i;
            end else if (w_in_range) begin
                rd_data_d = w_arr_data;
            end else begin
                rd_data_d = '0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data_o = rd_data_q;

endmodule : rf_read_port
`default_nettype wire

// File: rtl/reg_file_2r1w.sv
`default_nettype none
// ============================================================================
// Module  : reg_file_2r1w
// Purpose : WIDTH x DEPTH register file, one write / two registered read ports,
//           same-cycle bypass and a sequential bulk-clear engine.
//           Optional macro REGFILE_ZERO_REG_EN hardwires address 0 to zero.
// Revision: 1.0  initial release
// ============================================================================
module reg_file_2r1w
    import regfile_pkg::*;
#(
    parameter int WIDTH = RF_WIDTH_DEFAULT,
    parameter int DEPTH = RF_DEPTH_DEFAULT,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en1,
    input  logic [ADDR_W-1:0] rd_addr1,
    output logic [WIDTH-1:0]  rd_data1,
    input  logic              rd_en2,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic [WIDTH-1:0]  rd_data2,
    input  logic              clr_req,
    output logic              busy
);

    localparam logic [ADDR_W:0]   c_DEPTH_EXT = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] c_PTR_LAST  = ADDR_W'(DEPTH - 1);

    clr_state_e                 state_q;
    logic [ADDR_W-1:0]          ptr_q;
    logic                       busy_q;
    logic [DEPTH-1:0][WIDTH-1:0] mem_d;
    logic [DEPTH-1:0][WIDTH-1:0] mem_q;
    logic                       w_wr_in_range;
    logic                       w_wr_fire;

    assign w_wr_in_range = ({1'b0, wr_addr} < c_DEPTH_EXT);

`ifdef REGFILE_ZERO_REG_EN
    assign w_wr_fire = wr_en && !busy_q && w_wr_in_range && (wr_addr != '0);
`else
    assign w_wr_fire = wr_en && !busy_q && w_wr_in_range;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (clr_req) begin
                        state_q <= CLEAR;
                        ptr_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                CLEAR: begin
                    if (ptr_q == c_PTR_LAST) begin
                        state_q <= IDLE;
                        ptr_q   <= '0;
                        busy_q  <= 1'b0;
                    end else begin
                        ptr_q <= ptr_q + ADDR_W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    ptr_q   <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Writes and the clear walk never collide: writes are only accepted while idle.
    always_comb begin
        mem_d = mem_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_wr_fire && (wr_addr == ADDR_W'(i))) begin
                mem_d[i] = wr_data;
            end
            if ((state_q == CLEAR) && (ptr_q == ADDR_W'(i))) begin
                mem_d[i] = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_q <= '0;
        end else begin
            mem_q <= mem_d;
        end
    end

    rf_read_port #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_rd_port1 (
        .clk_i     (clk),
        .rst_ni    (rst),
        .rd_en_i   (rd_en1),
        .rd_addr_i (rd_addr1),
        .mem_i     (mem_q),
        .wr_fire_i (w_wr_fire),
        .wr_addr_i (wr_addr),
        .wr_data_i (wr_data),
        .rd_data_o (rd_data1)
    );

    rf_read_port #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_rd_port2 (
        .clk_i     (clk),
        .rst_ni    (rst),
        .rd_en_i   (rd_en2),
        .rd_addr_i (rd_addr2),
        .mem_i     (mem_q),
        .wr_fire_i (w_wr_fire),
        .wr_addr_i (wr_addr),
        .wr_data_i (wr_data),
        .rd_data_o (rd_data2)
    );

    assign busy = busy_q;

endmodule : reg_file_2r1w
`default_nettype wire

// File: tb/tb_reg_file_2r1w.sv
`default_nettype none
// ============================================================================
// Module  : tb_reg_file_2r1w
// Purpose : Scoreboard bench for reg_file_2r1w (DEPTH=16 and DEPTH=12 builds).
// Revision: 1.0  initial release
// ============================================================================
module tb_reg_file_2r1w;

`ifdef REGFILE_ZERO_REG_EN
    localparam bit c_ZERO = 1'b1;
`else
    localparam bit c_ZERO = 1'b0;
`endif

    logic        clk;
    logic        rst;

    // DEPTH = 16 instance
    logic        wr_en, rd_en1, rd_en2, clr_req, busy;
    logic [3:0]  wr_addr, rd_addr1, rd_addr2;
    logic [15:0] wr_data, rd_data1, rd_data2;

    // DEPTH = 12 instance
    logic        b_wr_en, b_rd_en1, b_rd_en2, b_clr_req, b_busy;
    logic [3:0]  b_wr_addr, b_rd_addr1, b_rd_addr2;
    logic [15:0] b_wr_data, b_rd_data1, b_rd_data2;

    int total = 0;
    int bad   = 0;

    logic [15:0] m_mem [16];
    logic [15:0] m_rd1, m_rd2;
    logic        m_busy;
    logic [3:0]  m_ptr;

    logic [15:0] q_rd1[$];
    logic [15:0] q_rd2[$];
    logic [15:0] q_busy[$];
    logic [15:0] q_b1[$];
    logic [15:0] q_b2[$];

    reg_file_2r1w dut (
        .clk(clk), .rst(rst),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en1(rd_en1), .rd_addr1(rd_addr1), .rd_data1(rd_data1),
        .rd_en2(rd_en2), .rd_addr2(rd_addr2), .rd_data2(rd_data2),
        .clr_req(clr_req), .busy(busy)
    );

    reg_file_2r1w #(.WIDTH(16), .DEPTH(12)) dut12 (
        .clk(clk), .rst(rst),
        .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
        .rd_en1(b_rd_en1), .rd_addr1(b_rd_addr1), .rd_data1(b_rd_data1),
        .rd_en2(b_rd_en2), .rd_addr2(b_rd_addr2), .rd_data2(b_rd_data2),
        .clr_req(b_clr_req), .busy(b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic idle_in();
        wr_en = 0; wr_addr = 0; wr_data = 0;
        rd_en1 = 0; rd_addr1 = 0; rd_en2 = 0; rd_addr2 = 0; clr_req = 0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_mem[i] = '0;
        m_rd1 = '0; m_rd2 = '0; m_busy = 1'b0; m_ptr = '0;
    endtask

    // Predict the edge from current inputs, queue results, then compare after the edge.
    task automatic step();
        logic        acc;
        logic [15:0] n1, n2;
        acc = wr_en && !m_busy && !(c_ZERO && wr_addr == 4'd0);
        n1 = m_rd1;
        n2 = m_rd2;
        if (rd_en1) n1 = (acc && wr_addr == rd_addr1) ? wr_data : m_mem[rd_addr1];
        if (rd_en2) n2 = (acc && wr_addr == rd_addr2) ? wr_data : m_mem[rd_addr2];
        if (acc) m_mem[wr_addr] = wr_data;
        if (m_busy) begin
            m_mem[m_ptr] = '0;
            if (m_ptr == 4'd15) begin
                m_busy = 1'b0;
                m_ptr  = '0;
            end else begin
                m_ptr = m_ptr + 4'd1;
            end
        end else if (clr_req) begin
            m_busy = 1'b1;
            m_ptr  = '0;
        end
        m_rd1 = n1;
        m_rd2 = n2;
        q_rd1.push_back(n1);
        q_rd2.push_back(n2);
        q_busy.push_back({15'd0, m_busy});
        @(posedge clk);
        #1;
        chk("rd_data1", rd_data1, q_rd1.pop_front());
        chk("rd_data2", rd_data2, q_rd2.pop_front());
        chk("busy", busy, q_busy.pop_front());
    endtask

    task automatic b_step();
        @(posedge clk);
        #1;
        if (q_b1.size() > 0) chk("d12_rd_data1", b_rd_data1, q_b1.pop_front());
        if (q_b2.size() > 0) chk("d12_rd_data2", b_rd_data2, q_b2.pop_front());
    endtask

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int busy_cnt;
        logic [15:0] zexp;

        rst = 1'b0;
        idle_in();
        b_wr_en = 0; b_wr_addr = 0; b_wr_data = 0; b_clr_req = 0;
        b_rd_en1 = 0; b_rd_addr1 = 0; b_rd_en2 = 0; b_rd_addr2 = 0;
        model_reset();

        #17;
        chk("reset_rd1", rd_data1, 16'h0000);
        chk("reset_rd2", rd_data2, 16'h0000);
        chk("reset_busy", busy, 1'b0);
        #1 rst = 1'b1;
        @(posedge clk); #1;

        // Basic write then read, then hold
        wr_en = 1; wr_addr = 4'd3; wr_data = 16'hBEEF;
        step();
        idle_in(); rd_en1 = 1; rd_addr1 = 4'd3;
        step();
        chk("basic_beef", rd_data1, 16'hBEEF);
        idle_in(); rd_addr1 = 4'd0;
        step();
        step();
        chk("hold_beef", rd_data1, 16'hBEEF);

        // Dual-port bypass
        wr_en = 1; wr_addr = 4'd5; wr_data = 16'h1234;
        rd_en1 = 1; rd_addr1 = 4'd5; rd_en2 = 1; rd_addr2 = 4'd5;
        step();
        chk("bypass1", rd_data1, 16'h1234);
        chk("bypass2", rd_data2, 16'h1234);
        idle_in();

        // Zero-register behaviour (bypass and later read)
        zexp = c_ZERO ? 16'h0000 : 16'hAAAA;
        wr_en = 1; wr_addr = 4'd0; wr_data = 16'hAAAA; rd_en1 = 1; rd_addr1 = 4'd0;
        step();
        chk("r0_bypass", rd_data1, zexp);
        idle_in(); rd_en2 = 1; rd_addr2 = 4'd0;
        step();
        chk("r0_later", rd_data2, zexp);
        idle_in();

        // Random mixed traffic
        for (int i = 0; i < 40; i++) begin
            wr_en = 1'($urandom_range(0, 1)); wr_addr = 4'($urandom);
            wr_data = 16'($urandom);
            rd_en1 = 1'($urandom_range(0, 1)); rd_addr1 = 4'($urandom);
            rd_en2 = 1'($urandom_range(0, 1)); rd_addr2 = 4'($urandom);
            step();
        end
        idle_in();

        // Fill with 0xFFFF, then bulk clear
        for (int i = 0; i < 16; i++) begin
            wr_en = 1; wr_addr = 4'(i); wr_data = 16'hFFFF;
            step();
        end
        idle_in(); clr_req = 1;
        busy_cnt = 0;
        step();
        if (busy) busy_cnt++;
        idle_in();
        for (int i = 1; i < 20; i++) begin
            idle_in();
            if (i == 3) begin
                wr_en = 1; wr_addr = 4'd7; wr_data = 16'h7777; rd_en1 = 1; rd_addr1 = 4'd7;
            end
            if (i == 5) begin
                rd_en1 = 1; rd_addr1 = 4'd15; clr_req = 1;
            end
            if (i == 12) begin
                wr_en = 1; wr_addr = 4'd7; wr_data = 16'h7777; rd_en2 = 1; rd_addr2 = 4'd7;
            end
            step();
            if (busy) busy_cnt++;
        end
        chk("busy_cycles", 32'(busy_cnt), 32'd16);
        idle_in();
        for (int i = 0; i < 16; i++) begin
            rd_en1 = 1; rd_addr1 = 4'(i); rd_en2 = 1; rd_addr2 = 4'(15 - i);
            step();
            chk("cleared", rd_data1, 16'h0000);
        end
        idle_in();

        // Reset in the middle of a clear
        wr_en = 1; wr_addr = 4'd2; wr_data = 16'h5A5A; step();
        wr_en = 1; wr_addr = 4'd9; wr_data = 16'hC3C3; step();
        idle_in(); rd_en1 = 1; rd_addr1 = 4'd2; rd_en2 = 1; rd_addr2 = 4'd9; step();
        idle_in(); clr_req = 1; step();
        idle_in();
        step(); step(); step();
        #2 rst = 1'b0;
        #1;
        chk("arst_busy", busy, 1'b0);
        chk("arst_rd1", rd_data1, 16'h0000);
        chk("arst_rd2", rd_data2, 16'h0000);
        model_reset();
        #3 rst = 1'b1;
        for (int i = 0; i < 16; i++) begin
            rd_en1 = 1; rd_addr1 = 4'(i);
            step();
        end
        idle_in(); wr_en = 1; wr_addr = 4'd9; wr_data = 16'h1111; step();
        idle_in(); rd_en2 = 1; rd_addr2 = 4'd9; step();
        chk("post_rst_write", rd_data2, 16'h1111);
        idle_in();

        // DEPTH = 12: out-of-range address handling
        for (int i = 0; i < 12; i++) begin
            b_wr_en = 1; b_wr_addr = 4'(i); b_wr_data = 16'(16'h0100 + i);
            b_step();
        end
        b_wr_en = 1; b_wr_addr = 4'd13; b_wr_data = 16'hDEAD;
        b_rd_en1 = 1; b_rd_addr1 = 4'd13;
        q_b1.push_back(16'h0000);
        b_step();
        b_wr_en = 0; b_rd_en1 = 1; b_rd_addr1 = 4'd11; b_rd_en2 = 1; b_rd_addr2 = 4'd13;
        q_b1.push_back(16'h010B); q_b2.push_back(16'h0000);
        b_step();
        for (int i = 0; i < 12; i++) begin
            b_rd_en1 = 1; b_rd_addr1 = 4'(i); b_rd_en2 = 1; b_rd_addr2 = 4'(15 - i);
            q_b1.push_back(16'(16'h0100 + i));
            q_b2.push_back((15 - i) < 12 ? 16'(16'h0100 + 15 - i) : 16'h0000);
            b_step();
        end
        b_rd_en1 = 0; b_rd_en2 = 0;

        chk("queues_drained", 32'(q_rd1.size() + q_b1.size() + q_b2.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_reg_file_2r1w
`default_nettype wire
